operand_feeder: RTL and testbench

Upstream stage for the registered `WIDTH`-bit adder (`c <= a + b`, one-cycle latency). It accepts operand pairs over a valid/ready handshake and buffers them in a `DEPTH`-entry FIFO. It issues at most one pair per cycle onto the adder's `a`/`b` inputs and produces `sum_valid`, which is aligned with the adder's `c` output. Downstream back-pressure (`hold`) and a synchronous `flush` control the issue rate.

---
 rtl/operand_feeder_pkg.sv | 29 ++
 rtl/operand_fifo_mem.sv | 32 +++
 rtl/operand_feeder.sv | 136 +++++++++++++
 tb/tb_operand_feeder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_feeder_pkg.sv
// operand_feeder_pkg: shared types and defaults for the operand feeder.
// Holds the FSM state enum, the {a,b} pair struct/builder and size defaults.
package operand_feeder_pkg;

  localparam int DEF_WIDTH = 40;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } pair_t;

  function automatic pair_t make_pair(
    input logic [DEF_WIDTH-1:0] a,
    input logic [DEF_WIDTH-1:0] b
  );
    pair_t p;
    p.a = a;
    p.b = b;
    return p;
  endfunction

endpackage

// File: rtl/operand_fifo_mem.sv
// operand_fifo_mem: DEPTH x W register array, one write port, one comb read.
// Ports: clk, rst (async low), we/waddr/wdata write, raddr/rdata read.
module operand_fifo_mem
  import operand_feeder_pkg::*;
#(
  parameter int W     = 2 * DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/operand_feeder.sv
// operand_feeder: FIFO-buffered operand issue stage for a registered adder.
// Ports: in_valid/in_ready/in_a/in_b push side; hold, flush issue control;
// a/b/issue to the adder; sum_valid aligned with adder c; level occupancy;
// issued_cnt counter, built only with OPERAND_FEEDER_STATS_EN defined.
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     hold,
  input  logic                     flush,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b,
  output logic                     issue,
  output logic                     sum_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LONE = LW'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [LW-1:0]        lvl_q;
  logic [LW-1:0]        lvl_d;
  state_t               state;
  state_t               state_d;
  logic                 push;
  logic                 wr;
  logic                 pop;
  logic [2*WIDTH-1:0]   head;

  // Handshake completes even during flush; only the write is dropped.
  assign push = in_valid && in_ready;
  assign wr   = push && !flush;
  assign pop  = (state != IDLE) && (lvl_q != '0)
             && !hold && !flush;

  operand_fifo_mem #(
    .W     (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wptr),
    .wdata ({in_a, in_b}),
    .raddr (rptr),
    .rdata (head)
  );

  always_comb begin
    lvl_d = lvl_q;
    if (flush) begin
      lvl_d = '0;
    end else if (wr && !pop) begin
      lvl_d = lvl_q + LONE;
    end else if (!wr && pop) begin
      lvl_d = lvl_q - LONE;
    end
  end

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (lvl_d == '0):         state_d = IDLE;
      (lvl_d != '0) && hold: state_d = STALL;
      default:               state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      lvl_q     <= '0;
      state     <= IDLE;
      in_ready  <= 1'b0;
      a         <= '0;
      b         <= '0;
      issue     <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      lvl_q     <= lvl_d;
      state     <= state_d;
      // No bypass: a pop cannot reopen a full FIFO in the same cycle.
      in_ready  <= (lvl_d < FULL);
      issue     <= pop;
      sum_valid <= issue && !flush;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr) begin
          wptr <= wptr + PONE;
        end
        if (pop) begin
          rptr <= rptr + PONE;
          a    <= head[2*WIDTH-1:WIDTH];
          b    <= head[WIDTH-1:0];
        end
      end
    end
  end

  assign level = lvl_q;

`ifdef OPERAND_FEEDER_STATS_EN
  logic [31:0] cnt_q;

  // Survives flush; only reset clears it. Wraps at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (issue) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign issued_cnt = cnt_q;
`else
  assign issued_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: table + directed + random checks of operand_feeder
// against a queue-based reference model, with a registered adder model.
module tb_operand_feeder;

  localparam int W = 40;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          issue;
  logic          sum_valid;
  logic [3:0]    level;
  logic [31:0]   issued_cnt;
  logic [W-1:0]  c;

  always #5 clk = ~clk;

  operand_feeder #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .hold       (hold),
    .flush      (flush),
    .a          (a),
    .b          (b),
    .issue      (issue),
    .sum_valid  (sum_valid),
    .level      (level),
    .issued_cnt (issued_cnt)
  );

  // The downstream registered adder.
  always_ff @(posedge clk) c <= a + b;

  int tests = 0;
  int fails = 0;

  logic [2*W-1:0] q[$];
  logic [W-1:0]   m_a, m_b, m_c;
  logic           m_issue, m_sv, m_ready;
  logic [31:0]    m_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_a = '0;
    m_b = '0;
    m_c = '0;
    m_issue = 1'b0;
    m_sv = 1'b0;
    m_ready = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_edge();
    logic acc, pp, iss_n, sv_n;
    logic [W-1:0] c_n;
    logic [2*W-1:0] hd;
    acc = in_valid && m_ready;
    pp = (q.size() != 0) && !hold && !flush;
    c_n = m_a + m_b;
    sv_n = m_issue && !flush;
`ifdef OPERAND_FEEDER_STATS_EN
    m_cnt = m_cnt + 32'(m_issue);
`endif
    iss_n = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) begin
        hd = q.pop_front();
        m_a = hd[2*W-1:W];
        m_b = hd[W-1:0];
        iss_n = 1'b1;
      end
      if (acc) q.push_back({in_a, in_b});
    end
    m_ready = (q.size() < D);
    m_c = c_n;
    m_sv = sv_n;
    m_issue = iss_n;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, in_ready, m_ready);
    chk({tag, ".level"}, level, q.size());
    chk({tag, ".issue"}, issue, m_issue);
    chk({tag, ".sum_valid"}, sum_valid, m_sv);
    chk({tag, ".a"}, a, m_a);
    chk({tag, ".b"}, b, m_b);
    if (m_sv) chk({tag, ".c"}, c, m_c);
    chk({tag, ".issued_cnt"}, issued_cnt, m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic h,
                       input logic f);
    in_valid = v;
    in_a = ia;
    in_b = ib;
    hold = h;
    flush = f;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_now");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
    #1;
    check_all("rst_rel");
    step("rst_first");
    chk("rst_ready_up", in_ready, 1'b1);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] ia;
    logic [W-1:0] ib;
    logic         h;
    logic         f;
    logic         e_ready;
    logic [3:0]   e_level;
    logic         e_issue;
    logic         e_sv;
    logic [W-1:0] e_a;
  } vec_t;

  vec_t tbl[8];
  logic [W-1:0] sums[$];
  logic [W-1:0] big;
  logic [31:0]  cnt0;
  int first_sv, last_sv;

  initial begin
    tbl[0] = '{1, 3, 4, 0, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 3};
    tbl[2] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 3};
    tbl[3] = '{1, 5, 6, 1, 0, 1, 1, 0, 0, 3};
    tbl[4] = '{1, 7, 8, 1, 0, 1, 2, 0, 0, 3};
    tbl[5] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 5};
    tbl[6] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 5};
    tbl[7] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 5};

    #2;
    do_reset();

    // Table: push (3,4) -> c=7, hold, flush with in-flight pair.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].ia, tbl[i].ib, tbl[i].h, tbl[i].f);
      step("tbl");
      chk($sformatf("tbl%0d.ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d.level", i), level, tbl[i].e_level);
      chk($sformatf("tbl%0d.issue", i), issue, tbl[i].e_issue);
      chk($sformatf("tbl%0d.sv", i), sum_valid, tbl[i].e_sv);
      chk($sformatf("tbl%0d.a", i), a, tbl[i].e_a);
      if (i == 2) chk("tbl2.c", c, 7);
    end

    // Fill under hold, then drain in order.
    for (int i = 0; i < D; i++) begin
      drive(1, W'(10 + i), W'(20 + i), 1, 0);
      step("fill");
    end
    chk("full.level", level, D);
    chk("full.ready", in_ready, 1'b0);
    chk("full.issue", issue, 1'b0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < D; i++) begin
      step("drain");
      chk($sformatf("drain%0d.issue", i), issue, 1'b1);
      chk($sformatf("drain%0d.a", i), a, W'(10 + i));
    end
    chk("drain.ready", in_ready, 1'b1);
    step("drain_end");
    chk("drain_end.issue", issue, 1'b0);

    // Continuous stream, 20 pairs through an 8-deep FIFO.
    first_sv = -1;
    last_sv = -1;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) drive(1, W'(i), 1, 0, 0);
      else drive(0, 0, 0, 0, 0);
      step("stream");
      if (sum_valid) begin
        sums.push_back(c);
        if (first_sv < 0) first_sv = i;
        last_sv = i;
      end
    end
    chk("stream.count", sums.size(), 20);
    chk("stream.gapless", last_sv - first_sv, 19);
    for (int k = 0; k < sums.size(); k++) begin
      chk($sformatf("stream.sum%0d", k), sums[k], W'(k + 1));
    end

    // Truncation at WIDTH.
    big = '1;
    drive(1, big, 1, 0, 0);
    step("ovf");
    drive(0, 0, 0, 0, 0);
    step("ovf");
    step("ovf");
    chk("ovf.sv", sum_valid, 1'b1);
    chk("ovf.c", c, 0);

    // Flush with a pair in flight and a push in the flush cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1, W'(100 + i), W'(200 + i), 1, 0);
      step("fl_fill");
    end
    drive(0, 0, 0, 0, 0);
    step("fl_issue");
    chk("fl_issue.a", a, 100);
    drive(1, 999, 999, 0, 1);
    step("fl");
    chk("fl.level", level, 0);
    chk("fl.sv", sum_valid, 1'b0);
    chk("fl.a", a, 100);
    chk("fl.b", b, 200);
    drive(0, 0, 0, 0, 0);
    step("fl_after");
    chk("fl_after.level", level, 0);
    drive(1, 7, 7, 0, 0);
    step("fl_push");
    drive(0, 0, 0, 0, 0);
    step("fl_pop");
    chk("fl_pop.a", a, 7);

    // Issue counter: 10 issues with a flush in between.
    step("cnt");
    cnt0 = issued_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        drive(1, W'(i), W'(r), 0, 0);
        step("cnt_push");
      end
      drive(0, 0, 0, 0, 0);
      repeat (3) step("cnt_drain");
      if (r == 0) begin
        drive(0, 0, 0, 0, 1);
        step("cnt_flush");
        drive(0, 0, 0, 0, 0);
      end
    end
`ifdef OPERAND_FEEDER_STATS_EN
    chk("cnt.delta", issued_cnt - cnt0, 10);
`else
    chk("cnt.zero", issued_cnt, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 70,
            {8'($urandom), $urandom}, {8'($urandom), $urandom},
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 4);
      step("rnd");
    end
    drive(0, 0, 0, 0, 0);
    repeat (D + 3) step("rnd_drain");

    // Asynchronous reset mid-stream with data buffered.
    for (int i = 0; i < 3; i++) begin
      drive(1, W'(50 + i), W'(60 + i), 1, 0);
      step("arst_fill");
    end
    drive(1, 1, 1, 0, 0);
    step("arst_issue");
    #3;
    do_reset();
    chk("arst.level", level, 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) step("arst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
